// File: rtl/fetch_pkg.sv
// Shared fetch types and line geometry; FETCH_HALT_ON_ZERO_EN adds the HALT state.
// Sysbus tag encodings fall back to local values when the system headers are absent.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

package fetch_pkg;
    localparam int LINE_BYTES     = 64;
    localparam int LINE_BEATS     = 8;
    localparam int WORDS_PER_LINE = 16;

    localparam logic [12:0] FETCH_READ_TAG = {`SYSBUS_READ, `SYSBUS_MEMORY, 8'h00};

`ifdef FETCH_HALT_ON_ZERO_EN
    typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, HALT} fetch_state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} fetch_state_t;
`endif
endpackage

// File: rtl/fetch_if.sv
// Sysbus request/response channels plus the decoder-facing instruction handshake.
interface fetch_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;
    logic                      inst_valid;
    logic [31:0]               inst;
    logic [63:0]               inst_pc;
    logic                      inst_ready;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output inst_valid, inst, inst_pc,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag, inst_ready
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  inst_valid, inst, inst_pc,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag, inst_ready
    );
endinterface

// File: rtl/fetch_line_buf.sv
// One cache line of beats: beat-indexed 64-bit write, word-indexed 32-bit combinational read.
import fetch_pkg::*;

module fetch_line_buf (
    input  logic        clk,
    input  logic        we_i,
    input  logic [2:0]  beat_i,
    input  logic [63:0] wdata_i,
    input  logic [3:0]  word_i,
    output logic [31:0] rdata_o
);
    logic [63:0] mem_q [LINE_BEATS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[beat_i] <= wdata_i;
        end
    end

    // Even words live in the low half of a beat, odd words in the high half.
    assign rdata_o = word_i[0] ? mem_q[word_i[3:1]][63:32] : mem_q[word_i[3:1]][31:0];
endmodule

// File: rtl/fetch_unit.sv
// Line-fill instruction fetch: inst_valid one cycle after beat 7, then 1 inst/cycle while inst_ready;
// inst/inst_pc held under backpressure. FETCH_HALT_ON_ZERO_EN stops fetch on a zero word.
import fetch_pkg::*;

module fetch_unit #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] entry,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    fetch_if.master     bus
);
    fetch_state_t              state_q, state_d;
    logic [63:0]               pc_q, pc_d;
    logic [2:0]                beat_cnt_q, beat_cnt_d;
    logic                      redirect_pend_q, redirect_pend_d;
    logic [BUS_DATA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [BUS_TAG_WIDTH-1:0]  req_tag_q, req_tag_d;

    logic        buf_we;
    logic [31:0] buf_word;
    logic [63:0] redir_pc;
    logic        reqcyc, respack, inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        unused_bits;

    assign redir_pc    = {redirect_pc[63:2], 2'b00};
    assign unused_bits = ^{bus.bus_resptag, redirect_pc[1:0]};

    fetch_line_buf u_line_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .beat_i  (beat_cnt_q),
        .wdata_i (64'(bus.bus_resp)),
        .word_i  (pc_q[5:2]),
        .rdata_o (buf_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            beat_cnt_q      <= '0;
            redirect_pend_q <= 1'b0;
            req_addr_q      <= '0;
            req_tag_q       <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            beat_cnt_q      <= beat_cnt_d;
            redirect_pend_q <= redirect_pend_d;
            req_addr_q      <= req_addr_d;
            req_tag_q       <= req_tag_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        beat_cnt_d      = beat_cnt_q;
        redirect_pend_d = redirect_pend_q;
        req_addr_d      = req_addr_q;
        req_tag_d       = req_tag_q;
        buf_we          = 1'b0;
        reqcyc          = 1'b0;
        respack         = 1'b0;
        inst_valid      = 1'b0;
        inst            = '0;
        inst_pc         = '0;

        case (state_q)
            IDLE: begin
                pc_d    = entry;
                state_d = REQ;
            end
            REQ: begin
                reqcyc = 1'b1;
                if (redirect_valid) begin
                    pc_d            = redir_pc;
                    redirect_pend_d = 1'b1;
                end
                if (bus.bus_reqack) begin
                    state_d    = RESP;
                    beat_cnt_d = '0;
                end
            end
            RESP: begin
                respack = bus.bus_respcyc;
                if (redirect_valid) begin
                    pc_d            = redir_pc;
                    redirect_pend_d = 1'b1;
                end
                if (bus.bus_respcyc) begin
                    buf_we     = 1'b1;
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (beat_cnt_q == 3'(LINE_BEATS - 1)) begin
                        // A redirect seen during the fill makes this line stale.
                        if (redirect_pend_q || redirect_valid) begin
                            state_d         = REQ;
                            redirect_pend_d = 1'b0;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
`ifdef FETCH_HALT_ON_ZERO_EN
                if (buf_word != '0) begin
                    inst_valid = 1'b1;
                    inst       = buf_word;
                    inst_pc    = pc_q;
                end
`else
                inst_valid = 1'b1;
                inst       = buf_word;
                inst_pc    = pc_q;
`endif
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
`ifdef FETCH_HALT_ON_ZERO_EN
                end else if (buf_word == '0) begin
                    state_d = HALT;
`endif
                end else if (bus.inst_ready) begin
                    pc_d = pc_q + 64'd4;
                    if (pc_q[5:2] == 4'(WORDS_PER_LINE - 1)) begin
                        state_d = REQ;
                    end
                end
            end
`ifdef FETCH_HALT_ON_ZERO_EN
            HALT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Request address/tag are captured on REQ entry and held until the ack edge.
        if (state_d == REQ && state_q != REQ) begin
            req_addr_d = BUS_DATA_WIDTH'({pc_d[63:6], 6'b0});
            req_tag_d  = BUS_TAG_WIDTH'(FETCH_READ_TAG);
        end else if (state_q == REQ && state_d != REQ) begin
            req_addr_d = '0;
            req_tag_d  = '0;
        end
    end

    assign bus.bus_reqcyc  = reqcyc;
    assign bus.bus_req     = req_addr_q;
    assign bus.bus_reqtag  = req_tag_q;
    assign bus.bus_respack = respack;
    assign bus.inst_valid  = inst_valid;
    assign bus.inst        = inst;
    assign bus.inst_pc     = inst_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a Sysbus responder model plus an instruction monitor.
import fetch_pkg::*;

module tb_fetch_unit;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    fetch_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) fif ();

    fetch_unit #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (fif)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_inst_q[$];
    logic [63:0] exp_req_q[$];
    logic [63:0] zero_addr = 64'h6014;
    int          ack_delay = 1;
    bit          gap_en = 1'b0;
    bit          resp_busy = 1'b0;
    int          beat_idx = 0;
    int          fill_no = 0;
    int          no_drain_fill = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a == zero_addr) return 32'h0;
        return {4'hE, a[27:0]};
    endfunction

    function automatic logic [63:0] beat_at(input logic [63:0] line, input int i);
        logic [63:0] a;
        a = line + 64'(8 * i);
        return {word_at(a + 64'd4), word_at(a)};
    endfunction

    task automatic push_line(input logic [63:0] start, input int count);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            e.pc   = start + 64'(4 * k);
            e.word = word_at(e.pc);
            exp_inst_q.push_back(e);
        end
    endtask

    // Sysbus slave: acks only requests the test has announced, so an unannounced one parks in REQ.
    initial begin
        logic [63:0] a;
        bit          drains;
        fif.bus_reqack  = 1'b0;
        fif.bus_respcyc = 1'b0;
        fif.bus_resp    = '0;
        fif.bus_resptag = FETCH_READ_TAG;
        forever begin
            @(negedge clk);
            if (!reset && fif.bus_reqcyc && exp_req_q.size() > 0) begin
                resp_busy = 1'b1;
                a = exp_req_q.pop_front();
                check_eq("bus_req", fif.bus_req, a);
                check_eq("bus_reqtag", 64'(fif.bus_reqtag), 64'(FETCH_READ_TAG));
                repeat (ack_delay) @(posedge clk);
                #1 fif.bus_reqack = 1'b1;
                @(negedge clk);
                check_eq("req_hold", fif.bus_req, a);
                @(posedge clk);
                #1 fif.bus_reqack = 1'b0;
                for (int i = 0; i < LINE_BEATS; i++) begin
                    if (gap_en && (i == 3 || i == 6)) begin
                        fif.bus_respcyc = 1'b0;
                        @(negedge clk);
                        check_eq("respack_gap", 64'(fif.bus_respack), 64'd0);
                        @(posedge clk);
                        #1;
                    end
                    beat_idx        = i;
                    fif.bus_respcyc = 1'b1;
                    fif.bus_resp    = beat_at(a, i);
                    @(negedge clk);
                    check_eq("respack", 64'(fif.bus_respack), 64'd1);
                    @(posedge clk);
                    #1;
                end
                fif.bus_respcyc = 1'b0;
                drains = (fill_no != no_drain_fill);
                fill_no++;
                @(negedge clk);
                check_eq("valid_after_fill", 64'(fif.inst_valid), 64'(drains));
                resp_busy = 1'b0;
            end
        end
    end

    // Instruction monitor: pops on each accepted handshake, checks stability under backpressure.
    initial begin
        bit          stall_prev;
        logic [31:0] held_inst;
        logic [63:0] held_pc;
        exp_t        e;
        stall_prev = 1'b0;
        held_inst  = '0;
        held_pc    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("hold_valid", 64'(fif.inst_valid), 64'd1);
                    check_eq("hold_inst", 64'(fif.inst), 64'(held_inst));
                    check_eq("hold_pc", fif.inst_pc, held_pc);
                end
                stall_prev = fif.inst_valid && !fif.inst_ready && !redirect_valid;
                held_inst  = fif.inst;
                held_pc    = fif.inst_pc;
                if (fif.inst_valid && fif.inst_ready && !redirect_valid) begin
                    if (exp_inst_q.size() == 0) begin
                        check_eq("inst_extra", 64'(fif.inst_valid), 64'd0);
                    end else begin
                        e = exp_inst_q.pop_front();
                        check_eq("inst_pc", fif.inst_pc, e.pc);
                        check_eq("inst", 64'(fif.inst), 64'(e.word));
                    end
                end
            end
        end
    end

    task automatic do_reset(input logic [63:0] e);
        @(posedge clk);
        #1;
        reset          = 1'b1;
        entry          = e;
        fif.inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_reqcyc", 64'(fif.bus_reqcyc), 64'd0);
        check_eq("rst_req", fif.bus_req, 64'd0);
        check_eq("rst_reqtag", 64'(fif.bus_reqtag), 64'd0);
        check_eq("rst_respack", 64'(fif.bus_respack), 64'd0);
        check_eq("rst_valid", 64'(fif.inst_valid), 64'd0);
        check_eq("rst_inst", 64'(fif.inst), 64'd0);
        check_eq("rst_pc", fif.inst_pc, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("idle_reqcyc", 64'(fif.bus_reqcyc), 64'd0);
        @(negedge clk);
        check_eq("first_reqcyc", 64'(fif.bus_reqcyc), 64'd1);
        check_eq("first_req", fif.bus_req, {e[63:6], 6'b0});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_inst_q.size() != 0 || exp_req_q.size() != 0 || resp_busy) && n < 600);
        check_eq("done_in_time", 64'(exp_inst_q.size() + exp_req_q.size()), 64'd0);
    endtask

    task automatic check_park(input logic [63:0] a);
        @(negedge clk);
        check_eq("park_reqcyc", 64'(fif.bus_reqcyc), 64'd1);
        check_eq("park_req", fif.bus_req, a);
    endtask

    task automatic wait_pc(input logic [63:0] pc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fif.inst_valid && fif.inst_pc == pc) && n < 200);
        check_eq("reach_pc", fif.inst_pc, pc);
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        entry          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fif.inst_ready = 1'b1;

        // Cold start, full line, 2-cycle ack.
        ack_delay = 2;
        do_reset(64'h1000);
        exp_req_q.push_back(64'h1000);
        push_line(64'h1000, 16);
        wait_done();
        check_park(64'h1040);

        // Mid-line entry with response gaps.
        ack_delay = 1;
        gap_en    = 1'b1;
        do_reset(64'h2038);
        exp_req_q.push_back(64'h2000);
        push_line(64'h2038, 2);
        wait_done();
        check_park(64'h2040);
        gap_en = 1'b0;

        // Backpressure on word 3 for 5 cycles.
        do_reset(64'h3000);
        exp_req_q.push_back(64'h3000);
        push_line(64'h3000, 16);
        wait_pc(64'h3008);
        @(posedge clk);
        #1 fif.inst_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 fif.inst_ready = 1'b1;
        wait_done();
        check_park(64'h3040);

        // Redirect during RESP at beat 4: stale line is drained from the bus but not delivered.
        do_reset(64'h4000);
        no_drain_fill = fill_no;
        exp_req_q.push_back(64'h4000);
        exp_req_q.push_back(64'h8000);
        push_line(64'h8000, 16);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fif.bus_respcyc && beat_idx == 4) && n < 200);
        check_eq("reach_beat4", 64'(beat_idx), 64'd4);
        redirect_pc    = 64'h8000;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_done();
        check_park(64'h8040);

        // Redirect in DRAIN coincident with a handshake; low PC bits ignored.
        do_reset(64'h5000);
        exp_req_q.push_back(64'h5000);
        push_line(64'h5000, 3);
        exp_req_q.push_back(64'h8000);
        push_line(64'h8000, 16);
        wait_pc(64'h5008);
        @(posedge clk);
        #1;
        redirect_pc    = 64'h8003;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_done();
        check_park(64'h8040);

        // Zero word at 0x6014.
        do_reset(64'h6000);
        exp_req_q.push_back(64'h6000);
`ifdef FETCH_HALT_ON_ZERO_EN
        push_line(64'h6000, 5);
        wait_done();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("halt_reqcyc", 64'(fif.bus_reqcyc), 64'd0);
            check_eq("halt_valid", 64'(fif.inst_valid), 64'd0);
        end
        exp_req_q.push_back(64'h7000);
        push_line(64'h7000, 16);
        @(posedge clk);
        #1;
        redirect_pc    = 64'h7000;
        redirect_valid = 1'b1;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_done();
        check_park(64'h7040);
`else
        push_line(64'h6000, 16);
        wait_done();
        check_park(64'h6040);
`endif

        // Top-of-memory wrap.
        do_reset(64'hFFFF_FFFF_FFFF_FFF8);
        exp_req_q.push_back(64'hFFFF_FFFF_FFFF_FFC0);
        push_line(64'hFFFF_FFFF_FFFF_FFF8, 2);
        wait_done();
        check_park(64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
